// File: rtl/dpram_unloader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wvb_rdout_pkg
// Brief   : Shared widths, FSM states and FIFO entry type for the readout path.
// Revision: 1.0  initial release
// ============================================================================
package wvb_rdout_pkg;

   localparam int RDOUT_ADDR_W = 11;
   localparam int RDOUT_DATA_W = 16;
   localparam int RDOUT_LEN_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rdout_state_t;

   typedef struct packed {
      logic                    last;
      logic [RDOUT_DATA_W-1:0] data;
   } rdout_entry_t;

endpackage
`default_nettype wire

// File: rtl/dpram_unloader_if.sv
`default_nettype none
// ============================================================================
// Module  : dpram_unloader_if
// Brief   : Run/busy handshake, DPRAM port-B read bus and output word stream.
// Revision: 1.0  initial release
// ============================================================================
interface dpram_unloader_if #(
   parameter int ADDR_W = wvb_rdout_pkg::RDOUT_ADDR_W,
   parameter int DATA_W = wvb_rdout_pkg::RDOUT_DATA_W,
   parameter int LEN_W  = wvb_rdout_pkg::RDOUT_LEN_W
);
   logic              dpram_run;
   logic [LEN_W-1:0]  dpram_len;
   logic              dpram_busy;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_last;
   logic              m_ready;
   logic              err_len;
   logic              err_overlap;

   modport master (
      input  dpram_run, dpram_len, rd_data, m_ready,
      output dpram_busy, rd_en, rd_addr, m_data, m_valid, m_last,
             err_len, err_overlap
   );

   modport slave (
      output dpram_run, dpram_len, rd_data, m_ready,
      input  dpram_busy, rd_en, rd_addr, m_data, m_valid, m_last,
             err_len, err_overlap
   );
endinterface
`default_nettype wire

// File: rtl/dpram_unloader_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rdout_skid_fifo
// Brief   : Small first-word-fall-through FIFO with occupancy count output.
// Revision: 1.0  initial release
// ============================================================================
module rdout_skid_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 3
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign valid = (count != '0);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(push && !pop && count == CNT_W'(DEPTH)));
         assert (!(pop && count == '0));
      end
   end
endmodule
`default_nettype wire

// File: rtl/dpram_unloader.sv
`default_nettype none
// ============================================================================
// Module  : dpram_unloader
// Brief   : Streams dpram_len words from DPRAM port B onto a valid/ready link.
// Revision: 1.0  initial release
// ============================================================================
module dpram_unloader
   import wvb_rdout_pkg::*;
#(
   parameter int ADDR_W     = RDOUT_ADDR_W,
   parameter int DATA_W     = RDOUT_DATA_W,
   parameter int FIFO_DEPTH = 3
)(
   input  logic             clk,
   input  logic             rst_n,
   dpram_unloader_if.master bus
);
   localparam int                CNT_W   = ADDR_W + 1;
   localparam int                FC_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0]  MAX_LEN = CNT_W'(1) << ADDR_W;
   localparam logic [FC_W:0]     DEPTH_C = (FC_W + 1)'(FIFO_DEPTH);

   rdout_state_t      state;
   rdout_state_t      state_nxt;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  sent;
   logic              in_flight;
   logic              in_flight_last;
   logic              done_q;
   logic              busy_q;
   logic              err_len_q;
   logic              err_ovl_q;
   logic [FC_W-1:0]   fifo_count;
   logic [DATA_W:0]   head;
   logic              head_valid;
   logic              pop;
   logic              issue;
   logic              issue_last;
   logic              credit_ok;
   logic              len_big;
   logic              run_idle;

   assign len_big    = 32'(bus.dpram_len) > (32'd1 << ADDR_W);
   assign run_idle   = bus.dpram_run && (state == IDLE);
   // A read in flight already owns a FIFO slot, so it counts against credit.
   assign credit_ok  = ({1'b0, fifo_count} + {{FC_W{1'b0}}, in_flight}) < DEPTH_C;
   assign issue      = (state == READ) && (issued < len_q) && credit_ok;
   assign issue_last = issue && (issued == len_q - 1'b1);
   assign pop        = head_valid && bus.m_ready;

   always_comb begin
      state_nxt   = state;
      bus.rd_en   = 1'b0;
      bus.rd_addr = '0;
      case (state)
         IDLE:    if (run_idle && bus.dpram_len != '0) state_nxt = READ;
         READ: begin
            bus.rd_en   = issue;
            bus.rd_addr = issue ? issued[ADDR_W-1:0] : '0;
            if (issue_last) state_nxt = DRAIN;
         end
         // Hold DRAIN one cycle past the last handshake so busy covers it.
         DRAIN:   if (done_q) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         len_q          <= '0;
         issued         <= '0;
         sent           <= '0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
         err_len_q      <= 1'b0;
         err_ovl_q      <= 1'b0;
      end else begin
         state          <= state_nxt;
         busy_q         <= (state_nxt != IDLE);
         err_len_q      <= run_idle && len_big;
         err_ovl_q      <= bus.dpram_run && (state != IDLE);
         in_flight      <= issue;
         in_flight_last <= issue_last;
         done_q         <= (state == DRAIN) && pop && head[DATA_W];
         if (run_idle) begin
            len_q  <= len_big ? MAX_LEN : CNT_W'(bus.dpram_len);
            issued <= '0;
            sent   <= '0;
         end else begin
            if (issue) issued <= issued + 1'b1;
            if (pop)   sent   <= sent + 1'b1;
         end
      end
   end

   rdout_skid_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_flight),
      .wdata ({in_flight_last, bus.rd_data}),
      .pop   (pop),
      .rdata (head),
      .valid (head_valid),
      .count (fifo_count)
   );

   assign bus.dpram_busy  = busy_q;
   assign bus.err_len     = err_len_q;
   assign bus.err_overlap = err_ovl_q;
   assign bus.m_valid     = head_valid;
   assign bus.m_data      = head_valid ? head[DATA_W-1:0] : '0;
   assign bus.m_last      = head_valid & head[DATA_W];

   always_ff @(posedge clk) begin
      if (rst_n && pop) assert (sent < len_q);
   end
endmodule
`default_nettype wire

// File: tb/tb_dpram_unloader.sv
`default_nettype none
// ============================================================================
// Module  : tb_dpram_unloader
// Brief   : Randomised self-checking bench against a word-list reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_dpram_unloader;
   import wvb_rdout_pkg::*;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int LOG    = 16384;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   int   ready_mode = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dpram_unloader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dpram_unloader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // DPRAM port-B model: one-cycle registered read.
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.m_ready = 1'b1;
         1:       bus.m_ready = !bus.m_ready;
         default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Cumulative observation logs; tests work on deltas.
   rdout_entry_t      hs_log [LOG];
   int                hs_cyc [LOG];
   logic [ADDR_W-1:0] rd_addr_log [LOG];
   int                rd_cyc [LOG];
   int hs_n = 0, rd_n = 0, busy_n = 0, errl_n = 0, erro_n = 0, val_n = 0, stab_n = 0;
   logic         held = 1'b0;
   rdout_entry_t held_e;

   always @(negedge clk) begin
      if (bus.m_valid && bus.m_ready) begin
         hs_log[hs_n % LOG] = '{last: bus.m_last, data: bus.m_data};
         hs_cyc[hs_n % LOG] = cyc;
         hs_n++;
      end
      if (bus.rd_en) begin
         rd_addr_log[rd_n % LOG] = bus.rd_addr;
         rd_cyc[rd_n % LOG]      = cyc;
         rd_n++;
      end
      if (bus.dpram_busy)  busy_n++;
      if (bus.err_len)     errl_n++;
      if (bus.err_overlap) erro_n++;
      if (bus.m_valid)     val_n++;
      if (held && rst_n && (!bus.m_valid || bus.m_data !== held_e.data || bus.m_last !== held_e.last))
         stab_n++;
      held   = bus.m_valid && !bus.m_ready && rst_n;
      held_e = '{last: bus.m_last, data: bus.m_data};
   end

   function automatic int first_bad(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         rdout_entry_t g = hs_log[(base + i) % LOG];
         if (g.data !== mem[i] || g.last !== (i == n - 1)) return i;
      end
      return -1;
   endfunction

   function automatic int rd_bad(input int base, input int n);
      for (int i = 0; i < n; i++)
         if (rd_addr_log[(base + i) % LOG] !== ADDR_W'(i)) return i;
      return -1;
   endfunction

   task automatic fill_mem(input bit rnd);
      for (int a = 0; a < DEPTH; a++) mem[a] = rnd ? DATA_W'($urandom) : DATA_W'(a + 'h100);
   endtask

   task automatic run_xfer(input int len, output int t0);
      @(posedge clk); #2;
      bus.dpram_run = 1'b1;
      bus.dpram_len = 16'(len);
      t0 = cyc;
      @(posedge clk); #2;
      bus.dpram_run = 1'b0;
   endtask

   task automatic pulse_run_at(input int win, input int len);
      while (cyc < win) begin @(posedge clk); #2; end
      bus.dpram_run = 1'b1;
      bus.dpram_len = 16'(len);
      @(posedge clk); #2;
      bus.dpram_run = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk); #1;
         if (!bus.dpram_busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [63:0] outs;
      outs = {bus.dpram_busy, bus.rd_en, 5'b0, bus.rd_addr, bus.m_valid, bus.m_data,
              bus.m_last, bus.err_len, bus.err_overlap};
      tests++;
      if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", outs); end
      @(posedge clk); #2; rst_n = 1'b1;
      @(negedge clk); #1;
      tests++;
      if (bus.dpram_busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.rd_en !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: busy=%b valid=%b rd_en=%b expected 000",
                  bus.dpram_busy, bus.m_valid, bus.rd_en);
      end
   endtask

   task automatic test_basic();
      int t0, hb, rb, bb, bad; bit ok;
      fill_mem(1'b0); ready_mode = 0;
      hb = hs_n; rb = rd_n; bb = busy_n;
      run_xfer(10, t0); wait_idle(200, ok);
      tests++; if (!ok) begin fails++; $display("FAIL basic_timeout: busy=%b expected 0", bus.dpram_busy); end
      tests++; if (hs_n - hb !== 10) begin fails++; $display("FAIL basic_count: got %0d expected 10", hs_n - hb); end
      bad = first_bad(hb, 10);
      tests++; if (bad !== -1) begin fails++; $display("FAIL basic_words: first bad index %0d expected -1", bad); end
      tests++; if (busy_n - bb !== 13) begin fails++; $display("FAIL basic_busy_len: got %0d expected 13", busy_n - bb); end
      tests++;
      if (rd_cyc[rb % LOG] !== t0 + 1 || rd_addr_log[rb % LOG] !== '0) begin
         fails++;
         $display("FAIL basic_first_rd: cyc %0d addr %0d expected cyc %0d addr 0",
                  rd_cyc[rb % LOG] - t0, rd_addr_log[rb % LOG], 1);
      end
      tests++; if (hs_cyc[hb % LOG] !== t0 + 3) begin fails++; $display("FAIL basic_first_valid: got T+%0d expected T+3", hs_cyc[hb % LOG] - t0); end
      tests++; if (hs_cyc[(hb + 9) % LOG] !== t0 + 12) begin fails++; $display("FAIL basic_last_hs: got T+%0d expected T+12", hs_cyc[(hb + 9) % LOG] - t0); end
   endtask

   task automatic test_toggle();
      int t0, hb, rb, sb, bad; bit ok;
      fill_mem(1'b0); ready_mode = 1;
      hb = hs_n; rb = rd_n; sb = stab_n;
      run_xfer(10, t0); wait_idle(400, ok);
      tests++; if (!ok) begin fails++; $display("FAIL toggle_timeout: busy=%b expected 0", bus.dpram_busy); end
      tests++; if (hs_n - hb !== 10) begin fails++; $display("FAIL toggle_count: got %0d expected 10", hs_n - hb); end
      bad = first_bad(hb, 10);
      tests++; if (bad !== -1) begin fails++; $display("FAIL toggle_words: first bad index %0d expected -1", bad); end
      tests++; if (rd_n - rb !== 10) begin fails++; $display("FAIL toggle_reads: got %0d expected 10", rd_n - rb); end
      bad = rd_bad(rb, 10);
      tests++; if (bad !== -1) begin fails++; $display("FAIL toggle_addrs: first bad index %0d expected -1", bad); end
      tests++; if (stab_n - sb !== 0) begin fails++; $display("FAIL toggle_stable: got %0d violations expected 0", stab_n - sb); end
      ready_mode = 0;
   endtask

   task automatic test_zero_len();
      int t0, bb, rb, vb, eb;
      ready_mode = 0;
      bb = busy_n; rb = rd_n; vb = val_n; eb = errl_n;
      run_xfer(0, t0);
      repeat (8) @(negedge clk);
      #1;
      tests++;
      if (busy_n - bb !== 0 || rd_n - rb !== 0 || val_n - vb !== 0 || errl_n - eb !== 0) begin
         fails++;
         $display("FAIL zero_len: busy %0d rd %0d valid %0d err_len %0d expected all 0",
                  busy_n - bb, rd_n - rb, val_n - vb, errl_n - eb);
      end
   endtask

   task automatic test_len_clamp();
      int t0, hb, rb, eb, bad; bit ok;
      fill_mem(1'b1); ready_mode = 0;
      hb = hs_n; rb = rd_n; eb = errl_n;
      run_xfer(3000, t0); wait_idle(5000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL clamp_timeout: busy=%b expected 0", bus.dpram_busy); end
      tests++; if (errl_n - eb !== 1) begin fails++; $display("FAIL clamp_err_len: got %0d pulses expected 1", errl_n - eb); end
      tests++; if (hs_n - hb !== 2048) begin fails++; $display("FAIL clamp_count: got %0d expected 2048", hs_n - hb); end
      bad = first_bad(hb, 2048);
      tests++; if (bad !== -1) begin fails++; $display("FAIL clamp_words: first bad index %0d expected -1", bad); end
      bad = rd_bad(rb, 2048);
      tests++; if (rd_n - rb !== 2048 || bad !== -1) begin fails++; $display("FAIL clamp_addrs: reads %0d bad %0d expected 2048 -1", rd_n - rb, bad); end
   endtask

   task automatic test_overlap();
      int t0, hb, bb, ob, bad; bit ok;
      fill_mem(1'b1); ready_mode = 0;
      hb = hs_n; bb = busy_n; ob = erro_n;
      run_xfer(10, t0);
      pulse_run_at(t0 + 2, 5);
      pulse_run_at(t0 + 12, 5);
      wait_idle(200, ok);
      repeat (4) @(negedge clk);
      #1;
      tests++; if (!ok) begin fails++; $display("FAIL overlap_timeout: busy=%b expected 0", bus.dpram_busy); end
      tests++; if (erro_n - ob !== 2) begin fails++; $display("FAIL overlap_pulses: got %0d expected 2", erro_n - ob); end
      tests++; if (hs_n - hb !== 10) begin fails++; $display("FAIL overlap_count: got %0d expected 10", hs_n - hb); end
      bad = first_bad(hb, 10);
      tests++; if (bad !== -1) begin fails++; $display("FAIL overlap_words: first bad index %0d expected -1", bad); end
      tests++; if (busy_n - bb !== 13) begin fails++; $display("FAIL overlap_busy_len: got %0d expected 13", busy_n - bb); end
   endtask

   task automatic test_back_to_back();
      int t0, hb, ob, bad; bit ok;
      fill_mem(1'b1); ready_mode = 0;
      hb = hs_n; ob = erro_n;
      run_xfer(5, t0);
      pulse_run_at(t0 + 8, 7);
      pulse_run_at(t0 + 9, 7);
      wait_idle(200, ok);
      tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout: busy=%b expected 0", bus.dpram_busy); end
      tests++; if (erro_n - ob !== 1) begin fails++; $display("FAIL b2b_overlap: got %0d expected 1", erro_n - ob); end
      tests++; if (hs_n - hb !== 12) begin fails++; $display("FAIL b2b_count: got %0d expected 12", hs_n - hb); end
      bad = first_bad(hb, 5);
      tests++; if (bad !== -1) begin fails++; $display("FAIL b2b_words_a: first bad index %0d expected -1", bad); end
      bad = first_bad(hb + 5, 7);
      tests++; if (bad !== -1) begin fails++; $display("FAIL b2b_words_b: first bad index %0d expected -1", bad); end
      tests++; if (hs_cyc[(hb + 5) % LOG] !== t0 + 12) begin fails++; $display("FAIL b2b_second_start: got T+%0d expected T+12", hs_cyc[(hb + 5) % LOG] - t0); end
   endtask

   task automatic test_mid_reset();
      int t0, hb, rb, bad; bit ok;
      logic [63:0] outs;
      fill_mem(1'b1); ready_mode = 0;
      hb = hs_n;
      run_xfer(10, t0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (hs_n - hb >= 5) begin ok = 1'b1; break; end
      end
      tests++; if (!ok) begin fails++; $display("FAIL midrst_timeout: words %0d expected 5", hs_n - hb); end
      rst_n = 1'b0;
      #1;
      outs = {bus.dpram_busy, bus.rd_en, 5'b0, bus.rd_addr, bus.m_valid, bus.m_data,
              bus.m_last, bus.err_len, bus.err_overlap};
      tests++; if (outs !== '0) begin fails++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
      @(posedge clk); #2; rst_n = 1'b1;
      tests++; if (hs_n - hb !== 5) begin fails++; $display("FAIL midrst_partial: got %0d expected 5", hs_n - hb); end
      hb = hs_n; rb = rd_n;
      run_xfer(4, t0); wait_idle(200, ok);
      tests++; if (!ok) begin fails++; $display("FAIL midrst_rerun_timeout: busy=%b expected 0", bus.dpram_busy); end
      bad = first_bad(hb, 4);
      tests++; if (hs_n - hb !== 4 || bad !== -1) begin fails++; $display("FAIL midrst_rerun_words: count %0d bad %0d expected 4 -1", hs_n - hb, bad); end
      bad = rd_bad(rb, 4);
      tests++; if (rd_n - rb !== 4 || bad !== -1) begin fails++; $display("FAIL midrst_rerun_addrs: reads %0d bad %0d expected 4 -1", rd_n - rb, bad); end
   endtask

   task automatic test_random();
      int t0, n, hb, rb, sb, eb, bad; bit ok;
      for (int it = 0; it < 6; it++) begin
         fill_mem(1'b1); ready_mode = 2;
         n = $urandom_range(1, 64);
         hb = hs_n; rb = rd_n; sb = stab_n; eb = erro_n + errl_n;
         run_xfer(n, t0); wait_idle(2000, ok);
         tests++; if (!ok) begin fails++; $display("FAIL rand_timeout: len %0d busy=%b expected 0", n, bus.dpram_busy); end
         tests++; if (hs_n - hb !== n) begin fails++; $display("FAIL rand_count: got %0d expected %0d", hs_n - hb, n); end
         bad = first_bad(hb, n);
         tests++; if (bad !== -1) begin fails++; $display("FAIL rand_words: len %0d first bad index %0d expected -1", n, bad); end
         bad = rd_bad(rb, n);
         tests++; if (rd_n - rb !== n || bad !== -1) begin fails++; $display("FAIL rand_addrs: reads %0d bad %0d expected %0d -1", rd_n - rb, bad, n); end
         tests++; if (stab_n - sb !== 0 || erro_n + errl_n - eb !== 0) begin fails++; $display("FAIL rand_stable_err: stab %0d err %0d expected 0 0", stab_n - sb, erro_n + errl_n - eb); end
      end
      ready_mode = 0;
   endtask

   initial begin
      bus.dpram_run = 1'b0;
      bus.dpram_len = '0;
      repeat (3) @(posedge clk);
      #2;
      test_reset();
      test_basic();
      test_toggle();
      test_zero_len();
      test_len_clamp();
      test_overlap();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/dpram_unloader.md
# dpram_unloader

Consumer end of the waveform-reader direct-readout DPRAM handshake. When the writer pulses `dpram_run`, the block takes `dpram_len` words from port B of the direct-readout DPRAM in ascending address order and streams them out on a valid/ready word stream toward the host link. It holds `dpram_busy` for the whole transfer, which tells the writer the DPRAM is owned by the consumer. It replaces the behavioural port-B model used in simulation with synthesizable RTL.

## Interface
- `ADDR_W`, 11: DPRAM port-B address width; maximum transfer is 2^ADDR_W words.
- `DATA_W`, 16: DPRAM port-B word width.
- `FIFO_DEPTH`, 3: output buffer entries; the minimum for one word per cycle.

- `clk`  in  1  single clock for both the DPRAM port B and the stream.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dpram_run`  in  1  one-cycle start pulse from the writer.
- `dpram_len`  in  16  transfer length in words; sampled on the `dpram_run` cycle.
- `dpram_busy`  out  1  high from the cycle after an accepted run until the cycle after the last word is accepted downstream.
- `rd_en`  out  1  port-B read enable.
- `rd_addr`  out  ADDR_W  port-B address.
- `rd_data`  in  DATA_W  port-B data, valid exactly one cycle after `rd_en`.
- `m_data`  out  DATA_W  stream word.
- `m_valid`  out  1  stream word valid.
- `m_last`  out  1  marks the final word of the transfer.
- `m_ready`  in  1  sink accepts the word; a handshake is `m_valid && m_ready`.
- `err_len`  out  1  one-cycle pulse when `dpram_len` > 2^ADDR_W.
- `err_overlap`  out  1  one-cycle pulse when `dpram_run` arrives while busy.

## Operation
- Reset values: all outputs 0. The FSM goes to IDLE. All counters clear. Buffered and in-flight words are discarded. Reset takes effect asynchronously, mid-transfer included.
- State machine, states IDLE, READ, DRAIN:
  - IDLE: on `dpram_run`, latch `len_q`.
    - If `dpram_len` = 0: no transition; `dpram_busy` never asserts.
    - If `dpram_len` > 2^ADDR_W: clamp `len_q` to 2^ADDR_W and pulse `err_len`.
    - Otherwise go to READ.
  - READ: issue reads while `issued < len_q` and `in_flight + fifo_count < FIFO_DEPTH`. Each issue drives `rd_en`=1 with `rd_addr`=`issued`, then increments `issued`. After the last issue, go to DRAIN.
  - DRAIN: wait until the word carrying `m_last` is handshaken, then go to IDLE.
- `dpram_busy` = (state != IDLE), registered.
- `dpram_run` while busy: ignored, with a one-cycle `err_overlap` pulse.
- Read data is written into the FIFO on the cycle after `rd_en`. Tag each entry with `last` = (its address == `len_q` − 1).
- `m_data`, `m_valid` and `m_last` come straight from the FIFO head.
- `m_data` and `m_last` stay stable while `m_valid && !m_ready`.
- The FIFO never overflows: the credit check counts in-flight reads. Overflow is an assertion failure.
- Width rules:
  - `issued` and the sent counter are ADDR_W+1 bits, so 2^ADDR_W is representable.
  - `rd_addr` = `issued[ADDR_W-1:0]`; it never wraps within a transfer.

## Timing
- `dpram_run` at cycle T: `dpram_busy`=1 at T+1, first `rd_en` at T+1 (addr 0), first `m_valid` at T+3.
- With `m_ready` held high, the block delivers one word per cycle. Last handshake at T+N+2; `dpram_busy` falls at T+N+3.
- A stall of k cycles on `m_ready` delays the completion by exactly k cycles. No word is lost or duplicated.
- The earliest new run is accepted at the first IDLE cycle: the cycle `dpram_busy` reads 0.
- Simultaneous last handshake and `dpram_run`: the run is ignored with `err_overlap`, since the state is still DRAIN.

## Structure
- Package `wvb_rdout_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults;
  - the `rdout_state_t` enum {IDLE, READ, DRAIN};
  - the FIFO entry typedef {last, data}.
- Sub-module `rdout_skid_fifo`: synchronous FIFO, depth FIFO_DEPTH, first-word-fall-through, with a `count` output used for credit accounting.
- The top level holds the FSM, counters and error pulses.

## Test plan
- `dpram_len`=10 with DPRAM preloaded with addr+0x100, `m_ready`=1 → words 0x100..0x109 on consecutive cycles; `m_last` on 0x109; `dpram_busy` high for exactly 13 cycles.
- `dpram_len`=10 with `m_ready` toggling 1/0 every cycle → same 10 words in order; `rd_addr` never exceeds 9; the FIFO never overflows.
- `dpram_len`=0 → `dpram_busy` stays 0, no `rd_en`, no `m_valid`. `dpram_len`=3000 → `err_len` pulse and 2048 words, with `m_last` at address 2047.
- `dpram_run` repeated 2 cycles into a 10-word transfer, and again on the last-handshake cycle → two `err_overlap` pulses; the transfer completes unaffected.
- `rst_n` low for 1 cycle during word 5 → all outputs 0 immediately, FSM in IDLE; a new `dpram_run` with length 4 then yields addresses 0..3 correctly.
